// File: rtl/mem_io_bridge.sv
// mem_io_bridge: core memory bus bridge to word RAM, an LED register and a UART transmitter.
// Ports:
//   clk, reset (sync, active-low)
//   mem_addr/mem_wdata/mem_wmask/mem_rstrb  core bus request
//   mem_rdata (registered, one cycle after mem_rstrb), mem_rbusy (always 0), mem_wbusy (TX queue full)
//   leds (LED register), uart_tx (8N1 serial, idle high)
// Build option: define UART_TX_FIFO_EN for a 4-entry TX queue; otherwise a single holding register.
module mem_io_bridge #(
  parameter int RAM_WORDS  = 1024,
  parameter int CLK_DIV    = 16,
  parameter int ADDR_WIDTH = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_rbusy,
  output logic        mem_wbusy,
  output logic [7:0]  leds,
  output logic        uart_tx
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int BW = $clog2(CLK_DIV);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  logic [31:0] addr;
  logic [31:0] io_rdata;
  logic [31:0] ram [RAM_WORDS];
  logic [AW-1:0] idx;
  logic is_io, leds_we, uart_we, enq, deq, full, empty, active, baud_end;
  logic unused_addr;
  logic [7:0] head;
  logic [7:0] shreg;
  logic [BW-1:0] baud;
  logic [2:0] bitc;
  tx_state_t state;
  // Bits above ADDR_WIDTH never reach the decoder.
  assign addr = mem_addr & ~(32'hffff_ffff << ADDR_WIDTH);
  assign unused_addr = ^addr;
  assign is_io = addr[22];
  assign idx = addr[AW+1:2];
  assign leds_we = is_io & addr[2] & mem_wmask[0];
  assign uart_we = is_io & addr[3] & mem_wmask[0];
  // A store into a full queue still lands when the transmitter frees a slot on the same edge.
  assign enq = uart_we & (~full | deq);
  assign baud_end = baud == BW'(CLK_DIV - 1);
  assign active = state != IDLE;
  assign deq = ~empty & ((state == IDLE) | ((state == STOP) & baud_end));
  assign io_rdata = addr[2] ? {24'b0, leds} : addr[4] ? {22'b0, full, active, 8'b0} : 32'b0;
  assign mem_rbusy = 1'b0;
  assign mem_wbusy = full;
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_wmask[i] & ~is_io) ram[idx][8*i +: 8] <= mem_wdata[8*i +: 8];
  end
  // RAM read uses the pre-store word when a store and read collide.
  always_ff @(posedge clk) begin
    if (!reset) mem_rdata <= 32'b0;
    else if (mem_rstrb) mem_rdata <= is_io ? io_rdata : ram[idx];
  end
  always_ff @(posedge clk) begin
    if (!reset) leds <= 8'b0;
    else if (leds_we) leds <= mem_wdata[7:0];
  end
`ifdef UART_TX_FIFO_EN
  logic [7:0] q [4];
  logic [1:0] wp, rp;
  logic [2:0] cnt, cnt_nx;
  assign cnt_nx = cnt + {2'b0, enq} - {2'b0, deq};
  assign empty = cnt == 3'd0;
  assign head = q[rp];
  always_ff @(posedge clk) begin
    if (enq) q[wp] <= mem_wdata[7:0];
    if (!reset) begin
      wp <= 2'd0;
      rp <= 2'd0;
      cnt <= 3'd0;
      full <= 1'b0;
    end else begin
      if (enq) wp <= wp + 2'd1;
      if (deq) rp <= rp + 2'd1;
      cnt <= cnt_nx;
      full <= cnt_nx == 3'd4;
    end
  end
`else
  logic occ;
  logic [7:0] hold;
  assign empty = ~occ;
  assign full = occ;
  assign head = hold;
  always_ff @(posedge clk) begin
    if (enq) hold <= mem_wdata[7:0];
    if (!reset) occ <= 1'b0;
    else occ <= enq | (occ & ~deq);
  end
`endif
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      baud <= '0;
      bitc <= 3'd0;
      shreg <= 8'b0;
      uart_tx <= 1'b1;
    end else begin
      case (state)
        IDLE: if (!empty) begin
          state <= START;
          shreg <= head;
          baud <= '0;
          uart_tx <= 1'b0;
        end
        START: if (baud_end) begin
          state <= DATA;
          baud <= '0;
          bitc <= 3'd0;
          uart_tx <= shreg[0];
        end else baud <= baud + BW'(1);
        DATA: if (baud_end) begin
          baud <= '0;
          if (bitc == 3'd7) begin
            state <= STOP;
            uart_tx <= 1'b1;
          end else begin
            bitc <= bitc + 3'd1;
            shreg <= shreg >> 1;
            uart_tx <= shreg[1];
          end
        end else baud <= baud + BW'(1);
        STOP: if (baud_end) begin
          baud <= '0;
          // Back-to-back frames: go straight to the next start bit.
          if (!empty) begin
            state <= START;
            shreg <= head;
            uart_tx <= 1'b0;
          end else state <= IDLE;
        end else baud <= baud + BW'(1);
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_io_bridge.sv
// tb_mem_io_bridge: directed self-checking bench for mem_io_bridge (RAM, LEDs, UART, reset).
module tb_mem_io_bridge;
`ifdef UART_TX_FIFO_EN
  localparam bit FIFO = 1'b1;
`else
  localparam bit FIFO = 1'b0;
`endif
  localparam int DIV = 16;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [31:0] mem_addr = 32'b0;
  logic [31:0] mem_wdata = 32'b0;
  logic [3:0] mem_wmask = 4'b0;
  logic mem_rstrb = 1'b0;
  logic [31:0] mem_rdata;
  logic mem_rbusy, mem_wbusy, uart_tx;
  logic [7:0] leds;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  mem_io_bridge #(.RAM_WORDS(1024), .CLK_DIV(DIV), .ADDR_WIDTH(24)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
    .mem_rbusy(mem_rbusy), .mem_wbusy(mem_wbusy), .leds(leds), .uart_tx(uart_tx)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    mem_addr = a;
    mem_wdata = d;
    mem_wmask = m;
    @(posedge clk);
    #1;
    mem_wmask = 4'b0;
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    mem_addr = a;
    mem_rstrb = 1'b1;
    @(posedge clk);
    #1;
    mem_rstrb = 1'b0;
    d = mem_rdata;
  endtask
  function automatic logic frame_bit(input logic [7:0] b, input int w);
    int k;
    k = w / DIV;
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction
  initial begin
    logic [31:0] d;
    logic [7:0] bytes [5];
    logic exp_tx, act_exp, busy_exp, saw_low;
    int nf, t, m;
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    repeat (3) @(posedge clk);
    #1;
    check("rst_leds", leds, 0);
    check("rst_tx", uart_tx, 1);
    check("rst_wbusy", mem_wbusy, 0);
    check("rst_rdata", mem_rdata, 0);
    check("rbusy", mem_rbusy, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    wr(32'h10, 32'hDEADBEEF, 4'b1111);
    wr(32'h11, 32'h00005500, 4'b0010);
    rd(32'h10, d);
    check("ram_lane", d, 32'hDEAD55EF);
    @(posedge clk);
    #1;
    check("ram_hold", mem_rdata, 32'hDEAD55EF);
    rd(32'hFF000010, d);
    check("addr_hi_ignored", d, 32'hDEAD55EF);
    wr(32'hFFC, 32'h12345678, 4'b1111);
    rd(32'hFFC, d);
    check("ram_last_word", d, 32'h12345678);
    wr(32'h20, 32'h11111111, 4'b1111);
    wr(32'h20, 32'hAB22CD44, 4'b1010);
    rd(32'h20, d);
    check("ram_mask_1010", d, 32'hAB11CD11);
    wr(32'h4, 32'hCAFEF00D, 4'b1111);
    wr(32'h400004, 32'h000000A5, 4'b0001);
    check("leds_store", leds, 8'hA5);
    rd(32'h400004, d);
    check("leds_read", d, 32'h000000A5);
    wr(32'h400004, 32'h000000FF, 4'b0010);
    check("leds_no_lane0", leds, 8'hA5);
    rd(32'h4, d);
    check("ram_not_io", d, 32'hCAFEF00D);
    rd(32'h400008, d);
    check("uart_data_read", d, 0);
    rd(32'h400020, d);
    check("unmapped_read", d, 0);
    rd(32'h400010, d);
    check("status_idle", d, 0);
    wr(32'h400008, 32'h41, 4'b0001);
    check("wbusy_single", mem_wbusy, FIFO ? 1'b0 : 1'b1);
    mem_addr = 32'h400010;
    mem_rstrb = 1'b1;
    for (int k = 1; k <= 170; k++) begin
      @(posedge clk);
      #1;
      t = k - 1;
      exp_tx = (t < 10 * DIV) ? frame_bit(8'h41, t) : 1'b1;
      act_exp = (k >= 2) && (k <= 10 * DIV + 1);
      busy_exp = !FIFO && (k == 1);
      check($sformatf("tx_41[%0d]", k), uart_tx, exp_tx);
      check($sformatf("status_41[%0d]", k), mem_rdata, {22'b0, busy_exp, act_exp, 8'b0});
    end
    mem_rstrb = 1'b0;
    nf = FIFO ? 5 : 2;
    for (int k = 0; k <= 10 * DIV * nf + 10; k++) begin
      if (k < 5) begin
        mem_addr = 32'h400008;
        mem_wdata = {24'b0, bytes[k]};
        mem_wmask = 4'b0001;
      end else mem_wmask = 4'b0;
      @(posedge clk);
      #1;
      if (k < 5) check($sformatf("wbusy_burst[%0d]", k), mem_wbusy, FIFO ? (k == 4) : 1'b1);
      if (k >= 1) begin
        t = k - 1;
        m = t / (10 * DIV);
        exp_tx = (m >= nf) ? 1'b1 : frame_bit(bytes[m], t % (10 * DIV));
        check($sformatf("tx_burst[%0d]", k), uart_tx, exp_tx);
      end
    end
    check("wbusy_drained", mem_wbusy, 0);
    wr(32'h400004, 32'h3C, 4'b0001);
    wr(32'h400008, 32'h41, 4'b0001);
    wr(32'h400008, 32'h42, 4'b0001);
    repeat (70) @(posedge clk);
    #1;
    check("tx_bit3", uart_tx, 0);
    check("leds_pre_rst", leds, 8'h3C);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst2_tx", uart_tx, 1);
    check("rst2_leds", leds, 0);
    check("rst2_wbusy", mem_wbusy, 0);
    check("rst2_rdata", mem_rdata, 0);
    reset = 1'b1;
    rd(32'h400010, d);
    check("status_after_rst", d, 0);
    saw_low = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (!uart_tx) saw_low = 1'b1;
    end
    check("no_tx_after_rst", saw_low, 0);
    rd(32'h10, d);
    check("ram_kept", d, 32'hDEAD55EF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
